// File: rtl/csi2tx_dphy_dat_lane_esc_tx.sv
// D-PHY data-lane escape-mode transmitter: spaced-one-hot LPDT, ULPS and trigger
// sequencing clocked by txclkesc, with every line drive and status output registered.
//
// state  | meaning
// STOP   | LP-11 Stop, waiting for an escape request
// ENTRY  | escape entry LP-10, LP-00, LP-01, LP-00
// CMD    | serializing the 8-bit entry command, first-listed bit first
// DATA   | serializing an LPDT byte, LSB first
// PAUSE  | LPDT with no byte offered, LP-00
// ULPS   | ultra-low-power state, LP-00 with ulpsactivenot low
// WAKEUP | LP-10 held for WAKEUP_CYCLES, then Stop
// EXIT   | one Mark-1 exit symbol, then Stop
module csi2tx_dphy_dat_lane_esc_tx #(
    parameter int WAKEUP_CYCLES = 16
) (
    input  logic       txclkesc,
    input  logic       txclkesc_rst,
    input  logic       txrequestesc,
    input  logic       txlpdtesc,
    input  logic       txulpsesc,
    input  logic [3:0] txtriggeresc,
    input  logic [7:0] txdataesc,
    input  logic       txvalidesc,
    output logic       txreadyesc,
    output logic       lp_tx_dp,
    output logic       lp_tx_dn,
    output logic       stopstate,
    output logic       ulpsactivenot
);

    localparam int WAKE_W = (WAKEUP_CYCLES > 1) ? $clog2(WAKEUP_CYCLES) : 1;

    localparam logic [7:0] CMD_LPDT  = 8'b11100001;
    localparam logic [7:0] CMD_ULPS  = 8'b00011110;
    localparam logic [7:0] CMD_TRIG0 = 8'b01100010;
    localparam logic [7:0] CMD_TRIG1 = 8'b01011101;
    localparam logic [7:0] CMD_TRIG2 = 8'b00100001;
    localparam logic [7:0] CMD_TRIG3 = 8'b10100010;

    typedef enum logic [2:0] {
        ST_STOP, ST_ENTRY, ST_CMD, ST_DATA, ST_PAUSE, ST_ULPS, ST_WAKEUP, ST_EXIT
    } state_t;

    typedef enum logic [1:0] {MODE_LPDT, MODE_ULPS, MODE_TRIG} mode_t;

    state_t            state;
    mode_t             mode;
    logic [1:0]        lp_line;
    logic [7:0]        shreg;
    logic [3:0]        bits_left;
    logic              phase;
    logic [1:0]        ent_cnt;
    logic [WAKE_W-1:0] wake_cnt;

    logic              req_ok;
    mode_t             req_mode;
    logic [7:0]        req_code;
    logic              byte_done;
    logic              lpdt_slot;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [1:0] mark(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        req_ok   = 1'b1;
        req_mode = MODE_TRIG;
        req_code = 8'h00;
        if (txlpdtesc) begin
            req_mode = MODE_LPDT;
            req_code = CMD_LPDT;
        end else if (txulpsesc) begin
            req_mode = MODE_ULPS;
            req_code = CMD_ULPS;
        end else if (txtriggeresc[0]) begin
            req_code = CMD_TRIG0;
        end else if (txtriggeresc[1]) begin
            req_code = CMD_TRIG1;
        end else if (txtriggeresc[2]) begin
            req_code = CMD_TRIG2;
        end else if (txtriggeresc[3]) begin
            req_code = CMD_TRIG3;
        end else begin
            req_ok = 1'b0;
        end
    end

    // Every PAUSE cycle behaves like an LPDT byte boundary.
    assign byte_done = !phase && (bits_left == 4'd0);
    assign lpdt_slot = (state == ST_PAUSE) ||
                       (byte_done && ((state == ST_DATA) ||
                                      (state == ST_CMD && mode == MODE_LPDT)));

    always_ff @(posedge txclkesc) begin
        if (txclkesc_rst) begin
            state         <= ST_STOP;
            mode          <= MODE_LPDT;
            lp_line       <= 2'b11;
            shreg         <= 8'h00;
            bits_left     <= 4'd0;
            phase         <= 1'b0;
            ent_cnt       <= 2'd0;
            wake_cnt      <= '0;
            stopstate     <= 1'b1;
            ulpsactivenot <= 1'b1;
            txreadyesc    <= 1'b0;
        end else begin
            txreadyesc <= 1'b0;
            if (lpdt_slot) begin
                if (!txrequestesc) begin
                    lp_line <= 2'b10;
                    state   <= ST_EXIT;
                end else if (txvalidesc) begin
                    txreadyesc <= 1'b1;
                    lp_line    <= mark(txdataesc[0]);
                    shreg      <= {1'b0, txdataesc[7:1]};
                    bits_left  <= 4'd7;
                    phase      <= 1'b1;
                    state      <= ST_DATA;
                end else begin
                    lp_line <= 2'b00;
                    state   <= ST_PAUSE;
                end
            end else begin
                case (state)
                    ST_STOP: begin
                        lp_line       <= 2'b11;
                        stopstate     <= 1'b1;
                        ulpsactivenot <= 1'b1;
                        if (txrequestesc && req_ok) begin
                            mode      <= req_mode;
                            shreg     <= rev8(req_code);
                            ent_cnt   <= 2'd2;
                            lp_line   <= 2'b10;
                            stopstate <= 1'b0;
                            state     <= ST_ENTRY;
                        end
                    end
                    ST_ENTRY: begin
                        lp_line <= (ent_cnt == 2'd1) ? 2'b01 : 2'b00;
                        ent_cnt <= ent_cnt - 2'd1;
                        if (ent_cnt == 2'd0) begin
                            bits_left <= 4'd8;
                            phase     <= 1'b0;
                            state     <= ST_CMD;
                        end
                    end
                    ST_CMD, ST_DATA: begin
                        if (phase) begin
                            lp_line <= 2'b00;
                            phase   <= 1'b0;
                        end else if (bits_left != 4'd0) begin
                            lp_line   <= mark(shreg[0]);
                            shreg     <= {1'b0, shreg[7:1]};
                            bits_left <= bits_left - 4'd1;
                            phase     <= 1'b1;
                        end else if (mode == MODE_ULPS) begin
                            lp_line       <= 2'b00;
                            ulpsactivenot <= 1'b0;
                            state         <= ST_ULPS;
                        end else begin
                            lp_line <= 2'b10;
                            state   <= ST_EXIT;
                        end
                    end
                    ST_ULPS: begin
                        lp_line <= 2'b00;
                        if (!txrequestesc) begin
                            lp_line       <= 2'b10;
                            ulpsactivenot <= 1'b1;
                            wake_cnt      <= WAKE_W'(WAKEUP_CYCLES - 1);
                            state         <= ST_WAKEUP;
                        end
                    end
                    ST_WAKEUP: begin
                        if (wake_cnt == '0) begin
                            lp_line   <= 2'b11;
                            stopstate <= 1'b1;
                            state     <= ST_STOP;
                        end else begin
                            wake_cnt <= wake_cnt - 1'b1;
                        end
                    end
                    ST_EXIT: begin
                        lp_line   <= 2'b11;
                        stopstate <= 1'b1;
                        state     <= ST_STOP;
                    end
                    default: begin
                        lp_line   <= 2'b11;
                        stopstate <= 1'b1;
                        state     <= ST_STOP;
                    end
                endcase
            end
        end
    end

    assign lp_tx_dp = lp_line[1];
    assign lp_tx_dn = lp_line[0];

endmodule

// File: tb/tb_csi2tx_dphy_dat_lane_esc_tx.sv
// Scoreboard bench for the escape-mode transmitter: expected per-cycle line symbols
// and decoded bytes are queued by the stimulus and consumed by a negedge monitor.
module tb_csi2tx_dphy_dat_lane_esc_tx;

    logic       txclkesc = 1'b0;
    logic       txclkesc_rst = 1'b1;
    logic       txrequestesc = 1'b0;
    logic       txlpdtesc = 1'b0;
    logic       txulpsesc = 1'b0;
    logic [3:0] txtriggeresc = 4'b0000;
    logic [7:0] txdataesc = 8'h00;
    logic       txvalidesc = 1'b0;
    logic       txreadyesc;
    logic       lp_tx_dp;
    logic       lp_tx_dn;
    logic       stopstate;
    logic       ulpsactivenot;

    always #5 txclkesc = ~txclkesc;

    csi2tx_dphy_dat_lane_esc_tx #(.WAKEUP_CYCLES(16)) dut (
        .txclkesc      (txclkesc),
        .txclkesc_rst  (txclkesc_rst),
        .txrequestesc  (txrequestesc),
        .txlpdtesc     (txlpdtesc),
        .txulpsesc     (txulpsesc),
        .txtriggeresc  (txtriggeresc),
        .txdataesc     (txdataesc),
        .txvalidesc    (txvalidesc),
        .txreadyesc    (txreadyesc),
        .lp_tx_dp      (lp_tx_dp),
        .lp_tx_dn      (lp_tx_dn),
        .stopstate     (stopstate),
        .ulpsactivenot (ulpsactivenot)
    );

    int checks = 0;
    int failures = 0;

    // entry = {last, dp, dn, stopstate, ulpsactivenot, txreadyesc}
    logic [5:0] sb_q[$];
    logic [7:0] exp_bytes[$];
    int         exp_nbits[$];
    bit         dec_bits[$];
    bit         mon_en = 1'b0;
    bit         armed = 1'b0;
    logic       prev_x = 1'b0;
    logic [5:0] exp_e;
    int         sym_idx = 0;

    task automatic push(input logic [1:0] ln, input logic ss, input logic ulpn,
                        input logic rdy, input logic last);
        sb_q.push_back({last, ln, ss, ulpn, rdy});
    endtask

    task automatic push_bit(input logic b, input logic rdy);
        push(b ? 2'b10 : 2'b01, 1'b0, 1'b1, rdy, 1'b0);
        push(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_entry();
        push(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        push(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        push(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) push_bit(c[i], 1'b0);
    endtask

    task automatic push_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) push_bit(d[i], i == 0);
    endtask

    task automatic push_exit_stop();
        push(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        push(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic cmp_byte(input string name, input logic [7:0] got);
        logic [7:0] e;
        checks++;
        if (exp_bytes.size() == 0) begin
            failures++;
            $display("FAIL %s got=%h exp=<none>", name, got);
        end else begin
            e = exp_bytes.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", name, got, e);
            end
        end
    endtask

    task automatic decode_check();
        int         en;
        logic [7:0] v;
        checks++;
        en = (exp_nbits.size() != 0) ? exp_nbits.pop_front() : -1;
        if (dec_bits.size() != en) begin
            failures++;
            $display("FAIL dec_nbits got=%0d exp=%0d", dec_bits.size(), en);
        end
        if (dec_bits.size() >= 10) begin
            for (int i = 0; i < 8; i++) v[7-i] = dec_bits[2+i];
            cmp_byte("dec_cmd", v);
            for (int j = 0; 17 + 8*j < dec_bits.size(); j++) begin
                for (int i = 0; i < 8; i++) v[i] = dec_bits[10 + 8*j + i];
                cmp_byte("dec_data", v);
            end
        end
    endtask

    always @(negedge txclkesc) begin
        if (mon_en) begin
            if (!armed && {lp_tx_dp, lp_tx_dn} != 2'b11) begin
                armed = 1'b1;
                prev_x = 1'b0;
                dec_bits.delete();
            end
            if (armed) begin
                if ((lp_tx_dp ^ lp_tx_dn) && !prev_x) dec_bits.push_back(lp_tx_dp);
                prev_x = lp_tx_dp ^ lp_tx_dn;
                checks++;
                sym_idx++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow sym=%0d got=%b%b exp=<none>",
                             sym_idx, lp_tx_dp, lp_tx_dn);
                    armed = 1'b0;
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({lp_tx_dp, lp_tx_dn, stopstate, ulpsactivenot, txreadyesc} !== exp_e[4:0]) begin
                        failures++;
                        $display("FAIL sym[%0d] got=%b exp=%b (dp dn stop ulpn rdy)", sym_idx,
                                 {lp_tx_dp, lp_tx_dn, stopstate, ulpsactivenot, txreadyesc},
                                 exp_e[4:0]);
                    end
                    if (exp_e[5]) begin
                        armed = 1'b0;
                        decode_check();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge txclkesc);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
            tick();
            if (txreadyesc === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s ready_timeout got=0 exp=1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            if (sb_q.size() == 0 && !armed) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s idle_timeout pending=%0d exp=0", name, sb_q.size());
            sb_q.delete();
            exp_bytes.delete();
            exp_nbits.delete();
            armed = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic lpdt_single(input string name, input logic ulps_too, input logic [7:0] d);
        push_entry();
        push_cmd(8'hE1);
        push_data(d);
        push_exit_stop();
        exp_nbits.push_back(19);
        exp_bytes.push_back(8'hE1);
        exp_bytes.push_back(d);
        txlpdtesc = 1'b1;
        txulpsesc = ulps_too;
        txdataesc = d;
        txvalidesc = 1'b1;
        txrequestesc = 1'b1;
        wait_ready(name);
        txvalidesc = 1'b0;
        txrequestesc = 1'b0;
        txlpdtesc = 1'b0;
        txulpsesc = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        checks++;
        if ({lp_tx_dp, lp_tx_dn, stopstate, ulpsactivenot, txreadyesc} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_state got=%b exp=11110",
                     {lp_tx_dp, lp_tx_dn, stopstate, ulpsactivenot, txreadyesc});
        end
        txclkesc_rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // request with no mode select is ignored
        txrequestesc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({lp_tx_dp, lp_tx_dn, stopstate} !== 3'b111) begin
                failures++;
                $display("FAIL no_mode_stay got=%b exp=111", {lp_tx_dp, lp_tx_dn, stopstate});
            end
        end
        txrequestesc = 1'b0;
        repeat (2) tick();

        lpdt_single("lpdt_a5", 1'b0, 8'hA5);

        // two bytes with a 5-cycle pause
        push_entry();
        push_cmd(8'hE1);
        push_data(8'h00);
        for (int i = 0; i < 5; i++) push(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        push_data(8'hFF);
        push_exit_stop();
        exp_nbits.push_back(27);
        exp_bytes.push_back(8'hE1);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'hFF);
        txlpdtesc = 1'b1;
        txdataesc = 8'h00;
        txvalidesc = 1'b1;
        txrequestesc = 1'b1;
        wait_ready("pause_b0");
        txlpdtesc = 1'b0;
        txvalidesc = 1'b0;
        repeat (20) tick();
        txdataesc = 8'hFF;
        txvalidesc = 1'b1;
        wait_ready("pause_b1");
        txvalidesc = 1'b0;
        txrequestesc = 1'b0;
        wait_idle("pause");

        // ULPS held 20 cycles, then 16-cycle wakeup
        push_entry();
        push_cmd(8'h1E);
        for (int i = 0; i < 20; i++) push(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) push(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exit_stop();
        exp_nbits.push_back(11);
        exp_bytes.push_back(8'h1E);
        txulpsesc = 1'b1;
        txrequestesc = 1'b1;
        tick();
        txulpsesc = 1'b0;
        repeat (39) tick();
        txrequestesc = 1'b0;
        wait_idle("ulps");

        // trigger 0 wins over trigger 2; request dropped during entry
        push_entry();
        push_cmd(8'h62);
        push_exit_stop();
        exp_nbits.push_back(11);
        exp_bytes.push_back(8'h62);
        txtriggeresc = 4'b0101;
        txrequestesc = 1'b1;
        tick();
        txrequestesc = 1'b0;
        txtriggeresc = 4'b0000;
        wait_idle("trig0");

        lpdt_single("lpdt_over_ulps", 1'b1, 8'h3C);

        // reset during third data bit, then trigger 1 straight after reset
        push_entry();
        push_cmd(8'hE1);
        push_bit(1'b0, 1'b1);
        push_bit(1'b1, 1'b0);
        push(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_nbits.push_back(13);
        exp_bytes.push_back(8'hE1);
        push_entry();
        push_cmd(8'h5D);
        push_exit_stop();
        exp_nbits.push_back(11);
        exp_bytes.push_back(8'h5D);
        txlpdtesc = 1'b1;
        txdataesc = 8'h5A;
        txvalidesc = 1'b1;
        txrequestesc = 1'b1;
        wait_ready("rst_mid");
        txlpdtesc = 1'b0;
        repeat (4) tick();
        txclkesc_rst = 1'b1;
        txvalidesc = 1'b0;
        txrequestesc = 1'b0;
        tick();
        txclkesc_rst = 1'b0;
        txtriggeresc = 4'b0010;
        txrequestesc = 1'b1;
        tick();
        txrequestesc = 1'b0;
        txtriggeresc = 4'b0000;
        wait_idle("rst_then_trig1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
